// File: rtl/lap_stopwatch.sv
// lap_stopwatch -- run/pause/clear stopwatch with 1 ms prescaler, lap capture
// and sticky overflow. Optional countdown mode is compiled in with the
// COUNTDOWN_EN macro. Without it the up-counting stopwatch is complete:
// dir/load inputs are ignored, done is tied low, and there is no DONE state.
//
// Parameters
//   CLK_PER_MS  clk cycles per 1 ms tick (>=1)
//   MIN_W       width of minute fields
//   MIN_MAX     minute modulus (minutes count 0..MIN_MAX-1)
//
// Ports
//   clk_i, reset_i            clock, synchronous active-high reset
//   start_i / stop_i / clr_i  level controls (clr > stop > start)
//   lap_i                     snapshot current time into lap_*_o
//   dir_i, load_i             count direction / preset strobe (countdown only)
//   load_sec_i, load_min_i    preset value (countdown only)
//   milisec_o, sec_o, min_o   current time
//   lap_milisec_o/sec_o/min_o captured time
//   running_o                 registered (state == RUN)
//   ovf_o                     sticky up-count wrap flag
//   done_o                    countdown reached zero (level while in DONE)
module lap_stopwatch #(
  parameter int CLK_PER_MS = 1,
  parameter int MIN_W      = 6,
  parameter int MIN_MAX    = 60
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             clr_i,
  input  logic             lap_i,
  input  logic             dir_i,
  input  logic             load_i,
  input  logic [5:0]       load_sec_i,
  input  logic [MIN_W-1:0] load_min_i,
  output logic [9:0]       milisec_o,
  output logic [5:0]       sec_o,
  output logic [MIN_W-1:0] min_o,
  output logic [9:0]       lap_milisec_o,
  output logic [5:0]       lap_sec_o,
  output logic [MIN_W-1:0] lap_min_o,
  output logic             running_o,
  output logic             ovf_o,
  output logic             done_o
);

  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(CLK_PER_MS - 1);
  localparam logic [MIN_W-1:0] MIN_LAST   = MIN_W'(MIN_MAX - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [9:0]       ms_q, ms_d, lap_ms_q, lap_ms_d;
  logic [5:0]       sec_q, sec_d, lap_sec_q, lap_sec_d;
  logic [MIN_W-1:0] min_q, min_d, lap_min_q, lap_min_d;
  logic             ovf_q, ovf_d;

  logic tick;
  logic time_zero;
  logic count_dn;   // this tick decrements instead of incrementing
  logic load_acc;   // preset accepted this cycle (never while running)

  assign tick      = (state_q == S_RUN) && (presc_q == PRESC_LAST);
  assign time_zero = (ms_q == 10'd0) && (sec_q == 6'd0) && (min_q == '0);

`ifdef COUNTDOWN_EN
  assign count_dn = dir_i;
  assign load_acc = load_i && (state_q != S_RUN);
`else
  assign count_dn = 1'b0;
  assign load_acc = 1'b0;
  logic unused_cd;
  assign unused_cd = ^{dir_i, load_i, load_sec_i, load_min_i};
`endif

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (stop_i)                     state_d = S_PAUSE;
          else if (count_dn && time_zero) state_d = S_DONE;
        end
        S_IDLE, S_PAUSE: begin
          // stop beats start, so a simultaneous start&stop stays put
          if (load_acc)              state_d = S_PAUSE;
          else if (start_i && !stop_i) state_d = S_RUN;
        end
        S_DONE: begin
          // start is deliberately ignored here; only load or clr leave DONE
          if (load_acc) state_d = S_PAUSE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Status outputs are registered from the next state so they line up with state_q.
  always_comb begin
    running_d = (state_d == S_RUN);
`ifdef COUNTDOWN_EN
    done_d    = (state_d == S_DONE);
`else
    done_d    = 1'b0;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  // ---------------------------------------------------------- datapath
  always_comb begin
    presc_d   = presc_q;
    ms_d      = ms_q;
    sec_d     = sec_q;
    min_d     = min_q;
    ovf_d     = ovf_q;
    lap_ms_d  = lap_ms_q;
    lap_sec_d = lap_sec_q;
    lap_min_d = lap_min_q;
    if (clr_i) begin
      presc_d   = '0;
      ms_d      = '0;
      sec_d     = '0;
      min_d     = '0;
      ovf_d     = 1'b0;
      lap_ms_d  = '0;
      lap_sec_d = '0;
      lap_min_d = '0;
    end else begin
      // prescaler advances only in RUN and holds otherwise
      if (state_q == S_RUN) presc_d = tick ? '0 : presc_q + PW'(1);

      // lap sees the registered (pre-tick) time
      if (lap_i) begin
        lap_ms_d  = ms_q;
        lap_sec_d = sec_q;
        lap_min_d = min_q;
      end

      if (load_acc) begin
        min_d = load_min_i;
        sec_d = load_sec_i;
        ms_d  = '0;
      end else if (tick && count_dn) begin
        // at zero the count holds; the FSM moves to DONE instead
        if (!time_zero) begin
          if (ms_q != 10'd0) begin
            ms_d = ms_q - 10'd1;
          end else begin
            ms_d = 10'd999;
            if (sec_q != 6'd0) begin
              sec_d = sec_q - 6'd1;
            end else begin
              sec_d = 6'd59;
              min_d = min_q - MIN_W'(1);
            end
          end
        end
      end else if (tick) begin
        if (ms_q != 10'd999) begin
          ms_d = ms_q + 10'd1;
        end else begin
          ms_d = '0;
          if (sec_q != 6'd59) begin
            sec_d = sec_q + 6'd1;
          end else begin
            sec_d = '0;
            if (min_q != MIN_LAST) begin
              min_d = min_q + MIN_W'(1);
            end else begin
              min_d = '0;
              ovf_d = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      presc_q   <= '0;
      ms_q      <= '0;
      sec_q     <= '0;
      min_q     <= '0;
      ovf_q     <= 1'b0;
      lap_ms_q  <= '0;
      lap_sec_q <= '0;
      lap_min_q <= '0;
    end else begin
      presc_q   <= presc_d;
      ms_q      <= ms_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      ovf_q     <= ovf_d;
      lap_ms_q  <= lap_ms_d;
      lap_sec_q <= lap_sec_d;
      lap_min_q <= lap_min_d;
    end
  end

  assign milisec_o     = ms_q;
  assign sec_o         = sec_q;
  assign min_o         = min_q;
  assign lap_milisec_o = lap_ms_q;
  assign lap_sec_o     = lap_sec_q;
  assign lap_min_o     = lap_min_q;
  assign running_o     = running_q;
  assign ovf_o         = ovf_q;
  assign done_o        = done_q;

endmodule
